mem_stage: RTL and testbench

- Memory-access pipeline stage directly downstream of the execute stage.
- Takes the ALU result (address or result), store data, memory length/write-enable and write-back control from EX.
- Performs the load or store over a req/ack data-memory bus and registers the result for write-back.
- Supplies forwarding information to the hazard unit and stalls the upstream pipeline while a bus access is outstanding.

---
 rtl/mem_stage_pkg.sv | 38 +++
 rtl/mem_stage_lane.sv | 50 +++++
 rtl/mem_stage.sv | 148 ++++++++++++++
 tb/tb_mem_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: access sizes, write-data
// select, FSM states, the held-instruction record and the alignment rule.
package mem_stage_pkg;

  localparam logic [1:0] MEMLEN_WORD  = 2'b00;
  localparam logic [1:0] MEMLEN_HALF  = 2'b01;
  localparam logic [1:0] MEMLEN_BYTE  = 2'b10;
  localparam logic [1:0] MEMLEN_UBYTE = 2'b11;

  localparam logic [1:0] CWD_ALU = 2'b00;
  localparam logic [1:0] CWD_MEM = 2'b01;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUS  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  typedef struct packed {
    logic        cregwa;
    logic [1:0]  cregwd;
    logic        regwe;
    logic [1:0]  memlen;
    logic        memwe;
    logic [31:0] rd2;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] aluout;
  } held_t;

  // Bytes never misalign; halves need addr[0]==0, words need addr[1:0]==0.
  function automatic logic is_misaligned(input logic [1:0] memlen, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (memlen == MEMLEN_WORD) bad = (addr_lo != 2'b00);
    else if (memlen == MEMLEN_HALF) bad = addr_lo[0];
    return bad;
  endfunction

endpackage

// File: rtl/mem_stage_lane.sv
// Combinational lane logic: store replication and byte enables, plus
// load lane selection with sign/zero extension.
module mem_lane
  import mem_stage_pkg::*;
(
  input  logic [1:0]  memlen,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  rbyte [4];
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rbyte[gi] = load_word[8*gi +: 8];
  end

  assign byte_sel = rbyte[addr_lo];
  assign half_sel = addr_lo[1] ? {rbyte[3], rbyte[2]} : {rbyte[1], rbyte[0]};

  always_comb begin
    be        = 4'b1111;
    wdata     = store_data;
    load_data = load_word;
    case (memlen)
      MEMLEN_HALF: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{store_data[15:0]}};
        load_data = {{16{half_sel[15]}}, half_sel};
      end
      MEMLEN_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {{24{byte_sel[7]}}, byte_sel};
      end
      MEMLEN_UBYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata     = {4{store_data[7:0]}};
        load_data = {24'h0, byte_sel};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: holds one instruction, runs a req/ack bus
// access with timeout when needed, and emits a one-cycle write-back bundle.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        cregwa_i,
  input  logic [1:0]  cregwd_i,
  input  logic        regwe_i,
  input  logic [1:0]  memlen_i,
  input  logic        memwe_i,
  input  logic [31:0] rd2_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] aluout_i,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall_o,
  output logic        we_mem,
  output logic [4:0]  wa_mem,
  output logic [31:0] wd_mem,
  output logic [1:0]  cwd_mem,
  output logic        out_valid,
  output logic        wb_we,
  output logic [4:0]  wb_wa,
  output logic [31:0] wb_wd,
  output logic        misalign,
  output logic        bus_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [1:0]       state_reg;
  held_t            hold_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             misalign_reg, bus_err_reg;
  logic             wb_we_reg;
  logic [4:0]       wb_wa_reg;
  logic [31:0]      wb_wd_reg;

  logic        accept, mem_op_in, misalign_in, in_bus, held;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata, lane_load;

  assign in_ready    = (state_reg == ST_IDLE);
  assign accept      = in_valid && in_ready;
  assign mem_op_in   = memwe_i || (cregwd_i == CWD_MEM);
  assign misalign_in = mem_op_in && is_misaligned(memlen_i, aluout_i[1:0]);
  assign in_bus      = (state_reg == ST_BUS);
  assign held        = (state_reg != ST_IDLE);

  mem_lane u_lane (
    .memlen     (hold_reg.memlen),
    .addr_lo    (hold_reg.aluout[1:0]),
    .store_data (hold_reg.rd2),
    .load_word  (dmem_rdata),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .load_data  (lane_load)
  );

  // Bus fields come straight from the holding registers, so they stay stable until ack.
  assign dmem_req   = in_bus;
  assign dmem_we    = in_bus && hold_reg.memwe;
  assign dmem_addr  = in_bus ? {hold_reg.aluout[31:2], 2'b00} : 32'h0;
  assign dmem_be    = in_bus ? lane_be : 4'h0;
  assign dmem_wdata = in_bus ? lane_wdata : 32'h0;

  assign stall_o = held || (in_valid && mem_op_in);

  assign we_mem  = held && hold_reg.regwe;
  assign wa_mem  = held ? (hold_reg.cregwa ? hold_reg.rd : hold_reg.rt) : 5'd0;
  assign wd_mem  = held ? hold_reg.aluout : 32'h0;
  assign cwd_mem = held ? hold_reg.cregwd : 2'b00;

  assign out_valid = (state_reg == ST_DONE);
  assign wb_we     = wb_we_reg;
  assign wb_wa     = wb_wa_reg;
  assign wb_wd     = wb_wd_reg;
  assign misalign  = misalign_reg;
  assign bus_err   = bus_err_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      hold_reg     <= '0;
      cnt_reg      <= '0;
      misalign_reg <= 1'b0;
      bus_err_reg  <= 1'b0;
      wb_we_reg    <= 1'b0;
      wb_wa_reg    <= 5'd0;
      wb_wd_reg    <= 32'h0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            hold_reg     <= '{cregwa: cregwa_i, cregwd: cregwd_i, regwe: regwe_i,
                              memlen: memlen_i, memwe: memwe_i, rd2: rd2_i,
                              rt: rt_i, rd: rd_i, aluout: aluout_i};
            misalign_reg <= misalign_in;
            bus_err_reg  <= 1'b0;
            cnt_reg      <= '0;
            wb_wa_reg    <= cregwa_i ? rd_i : rt_i;
            wb_wd_reg    <= aluout_i;
            if (mem_op_in && !misalign_in) begin
              state_reg <= ST_BUS;
            end else begin
              wb_we_reg <= regwe_i && !misalign_in;
              state_reg <= ST_DONE;
            end
          end
        end
        ST_BUS: begin
          // Ack takes priority over expiry when both land in the same cycle.
          if (dmem_ack) begin
            wb_we_reg <= hold_reg.regwe;
            wb_wd_reg <= (hold_reg.cregwd == CWD_MEM) ? lane_load : hold_reg.aluout;
            state_reg <= ST_DONE;
          end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
            bus_err_reg <= 1'b1;
            wb_we_reg   <= 1'b0;
            state_reg   <= ST_DONE;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_DONE: begin
          wb_we_reg <= 1'b0;
          wb_wa_reg <= 5'd0;
          wb_wd_reg <= 32'h0;
          state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stimulus pushes expected write-back bundles
// into a queue, a negedge monitor pops and compares on every out_valid.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        cregwa_i = 1'b0;
  logic [1:0]  cregwd_i = 2'b00;
  logic        regwe_i = 1'b0;
  logic [1:0]  memlen_i = 2'b00;
  logic        memwe_i = 1'b0;
  logic [31:0] rd2_i = 32'h0;
  logic [4:0]  rt_i = 5'd0;
  logic [4:0]  rd_i = 5'd0;
  logic [31:0] aluout_i = 32'h0;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic        stall_o, we_mem;
  logic [4:0]  wa_mem;
  logic [31:0] wd_mem;
  logic [1:0]  cwd_mem;
  logic        out_valid, wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        misalign, bus_err;

  mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .cregwa_i(cregwa_i), .cregwd_i(cregwd_i), .regwe_i(regwe_i),
    .memlen_i(memlen_i), .memwe_i(memwe_i), .rd2_i(rd2_i),
    .rt_i(rt_i), .rd_i(rd_i), .aluout_i(aluout_i),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall_o(stall_o), .we_mem(we_mem),
    .wa_mem(wa_mem), .wd_mem(wd_mem), .cwd_mem(cwd_mem),
    .out_valid(out_valid), .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .misalign(misalign), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        chk_wd;
  } exp_t;

  typedef struct {
    logic        cregwa;
    logic [1:0]  cregwd;
    logic        regwe;
    logic [1:0]  memlen;
    logic        memwe;
    logic [31:0] rd2;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] aluout;
  } ins_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  function automatic ins_t mk(input logic cregwa, input logic [1:0] cregwd, input logic regwe,
                              input logic [1:0] memlen, input logic memwe, input logic [31:0] rd2,
                              input logic [4:0] rt, input logic [4:0] rd, input logic [31:0] aluout);
    ins_t i;
    i.cregwa = cregwa; i.cregwd = cregwd; i.regwe = regwe; i.memlen = memlen;
    i.memwe = memwe; i.rd2 = rd2; i.rt = rt; i.rd = rd; i.aluout = aluout;
    return i;
  endfunction

  always @(negedge clk) begin
    if (rst && out_valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_out_valid", 32'(out_valid), 32'h0);
      end else begin
        mon_e = sb_q.pop_front();
        $display("wb: we=%0b wa=%0d wd=%h (expect we=%0b wa=%0d wd=%h)",
                 wb_we, wb_wa, wb_wd, mon_e.we, mon_e.wa, mon_e.wd);
        check("wb_we", 32'(wb_we), 32'(mon_e.we));
        check("wb_wa", 32'(wb_wa), 32'(mon_e.wa));
        if (mon_e.chk_wd) check("wb_wd", wb_wd, mon_e.wd);
      end
    end
  end

  task automatic drive(input ins_t i);
    cregwa_i = i.cregwa; cregwd_i = i.cregwd; regwe_i = i.regwe; memlen_i = i.memlen;
    memwe_i = i.memwe; rd2_i = i.rd2; rt_i = i.rt; rd_i = i.rd; aluout_i = i.aluout;
    in_valid = 1'b1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("ready_timeout", 32'(in_ready), 32'h1);
  endtask

  // ack_at: 0 = no bus access expected, -1 = bus access never acked, k>0 = ack in k-th req cycle
  task automatic do_op(input string name, input ins_t i, input int ack_at, input logic [31:0] rdata,
                       input logic [31:0] x_addr, input logic [3:0] x_be, input logic [31:0] x_wdata,
                       input logic x_we, input logic e_we, input logic [4:0] e_wa,
                       input logic [31:0] e_wd, input logic chk_wd);
    exp_t e;
    logic mem_op;
    wait_ready();
    mem_op = i.memwe || (i.cregwd == 2'b01);
    e.we = e_we; e.wa = e_wa; e.wd = e_wd; e.chk_wd = chk_wd;
    sb_q.push_back(e);
    $display("op %s: addr=%h rd2=%h ack_at=%0d rdata=%h", name, i.aluout, i.rd2, ack_at, rdata);
    drive(i);
    #1 check({name, "_stall_accept"}, 32'(stall_o), 32'(mem_op));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (ack_at == 0) begin
      check({name, "_no_req"}, 32'(dmem_req), 32'h0);
    end else begin
      check({name, "_req"}, 32'(dmem_req), 32'h1);
      check({name, "_addr"}, dmem_addr, x_addr);
      check({name, "_be"}, 32'(dmem_be), 32'(x_be));
      if (x_we) check({name, "_wdata"}, dmem_wdata, x_wdata);
      check({name, "_we"}, 32'(dmem_we), 32'(x_we));
      check({name, "_stall_bus"}, 32'(stall_o), 32'h1);
      check({name, "_fwd_we"}, 32'(we_mem), 32'(i.regwe));
      check({name, "_fwd_cwd"}, 32'(cwd_mem), 32'(i.cregwd));
      if (ack_at > 0) begin
        repeat (ack_at - 1) @(negedge clk);
        check({name, "_req_held"}, 32'(dmem_req), 32'h1);
        check({name, "_addr_held"}, dmem_addr, x_addr);
        dmem_ack = 1'b1;
        dmem_rdata = rdata;
        @(negedge clk);
        dmem_ack = 1'b0;
      end
    end
    wait_ready();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'h1);
    check("rst_req", 32'(dmem_req), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_stall", 32'(stall_o), 32'h0);
    check("rst_flags", {30'h0, misalign, bus_err}, 32'h0);
    check("rst_fwd", {we_mem, wa_mem, cwd_mem}, 32'h0);
    rst = 1'b1;
    @(negedge clk);

    do_op("alu", mk(1'b1, 2'b00, 1'b1, 2'b00, 1'b0, 32'h0, 5'd7, 5'd5, 32'h1234),
          0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b1, 5'd5, 32'h1234, 1'b1);
    do_op("sb", mk(1'b0, 2'b00, 1'b0, 2'b10, 1'b1, 32'hAABBCCDD, 5'd3, 5'd4, 32'h103),
          3, 32'h0, 32'h100, 4'b1000, 32'hDDDDDDDD, 1'b1, 1'b0, 5'd3, 32'h103, 1'b1);
    do_op("lb", mk(1'b0, 2'b01, 1'b1, 2'b10, 1'b0, 32'h0, 5'd9, 5'd1, 32'h102),
          1, 32'h00800000, 32'h100, 4'b0100, 32'h0, 1'b0, 1'b1, 5'd9, 32'hFFFFFF80, 1'b1);
    do_op("lbu", mk(1'b0, 2'b01, 1'b1, 2'b11, 1'b0, 32'h0, 5'd9, 5'd1, 32'h102),
          2, 32'h00800000, 32'h100, 4'b0100, 32'h0, 1'b0, 1'b1, 5'd9, 32'h00000080, 1'b1);
    do_op("lw_mis", mk(1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 32'h0, 5'd10, 5'd2, 32'h202),
          0, 32'h0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 5'd10, 32'h0, 1'b0);
    check("misalign_sticky", 32'(misalign), 32'h1);
    do_op("lh", mk(1'b1, 2'b01, 1'b1, 2'b01, 1'b0, 32'h0, 5'd0, 5'd11, 32'h206),
          1, 32'h80011234, 32'h204, 4'b1100, 32'h0, 1'b0, 1'b1, 5'd11, 32'hFFFF8001, 1'b1);
    check("misalign_cleared", 32'(misalign), 32'h0);
    do_op("lw_timeout", mk(1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 32'h0, 5'd12, 5'd0, 32'h300),
          -1, 32'h0, 32'h300, 4'b1111, 32'h0, 1'b0, 1'b0, 5'd12, 32'h0, 1'b0);
    check("bus_err_sticky", 32'(bus_err), 32'h1);
    do_op("lw_ack_last", mk(1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 32'h0, 5'd13, 5'd0, 32'h304),
          TO, 32'hCAFEBABE, 32'h304, 4'b1111, 32'h0, 1'b0, 1'b1, 5'd13, 32'hCAFEBABE, 1'b1);
    check("bus_err_cleared", 32'(bus_err), 32'h0);
    do_op("sh", mk(1'b0, 2'b00, 1'b0, 2'b01, 1'b1, 32'h1234ABCD, 5'd1, 5'd1, 32'h10),
          1, 32'h0, 32'h10, 4'b0011, 32'hABCDABCD, 1'b1, 1'b0, 5'd1, 32'h10, 1'b1);

    // Reset while a load is outstanding: no write-back may follow, even on a late ack.
    $display("op rst_in_bus: addr=00000400");
    drive(mk(1'b0, 2'b01, 1'b1, 2'b00, 1'b0, 32'h0, 5'd14, 5'd0, 32'h400));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("rstbus_req_before", 32'(dmem_req), 32'h1);
    #2 rst = 1'b0;
    #1;
    check("rstbus_req_dropped", 32'(dmem_req), 32'h0);
    check("rstbus_in_ready", 32'(in_ready), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    dmem_ack = 1'b1;
    dmem_rdata = 32'h12345678;
    @(negedge clk);
    dmem_ack = 1'b0;
    repeat (3) @(negedge clk);
    check("rstbus_no_out_valid", 32'(out_valid), 32'h0);
    check("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
